// File: rtl/dpram_be_if.sv
// Bus bundle for dpram_be: clear request, ready, two independent byte-enabled
// RAM ports and the collision flag. The master drives requests; the slave is the RAM.
interface dpram_be_if #(
   parameter int ADDR_W = 8,
   parameter int BYTES  = 1
);
   localparam int DATA_W = 8 * BYTES;

   logic              clr_req;
   logic              ready;

   logic              a_en;
   logic              a_we;
   logic [BYTES-1:0]  a_be;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic [DATA_W-1:0] a_rdata;
   logic              a_rvalid;

   logic              b_en;
   logic              b_we;
   logic [BYTES-1:0]  b_be;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic [DATA_W-1:0] b_rdata;
   logic              b_rvalid;

   logic              collision;

   modport master (
      output clr_req,
      input  ready,
      output a_en, a_we, a_be, a_addr, a_wdata,
      input  a_rdata, a_rvalid,
      output b_en, b_we, b_be, b_addr, b_wdata,
      input  b_rdata, b_rvalid,
      input  collision
   );

   modport slave (
      input  clr_req,
      output ready,
      input  a_en, a_we, a_be, a_addr, a_wdata,
      output a_rdata, a_rvalid,
      input  b_en, b_we, b_be, b_addr, b_wdata,
      output b_rdata, b_rvalid,
      output collision
   );
endinterface

// File: rtl/dpram_be.sv
// True dual-port byte-enabled RAM with clear sequencer and collision flag.
// Optional DPRAM_OUT_REG_EN adds a second read-data register stage (latency 2).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | zeroing one word per cycle at r_clr_cnt; ports ignored
// S_READY | both ports accept requests; clr_req restarts the clear
module dpram_be #(
   parameter int ADDR_W = 8,
   parameter int BYTES  = 1
) (
   input  logic       clk,
   input  logic       rst,
   dpram_be_if.slave  bus
);
   localparam int DATA_W = 8 * BYTES;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic [ADDR_W-1:0] w_clr_cnt_nxt;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_ready;
   logic              w_clr_wr;
   logic              w_a_rd;
   logic              w_b_rd;
   logic              w_a_wr;
   logic              w_b_wr;
   logic              w_a_eff_wr;
   logic              w_b_eff_wr;
   logic              w_same_addr;
   logic              w_collision;

   logic [DATA_W-1:0] r_a_rdata;
   logic              r_a_rvalid;
   logic [DATA_W-1:0] r_b_rdata;
   logic              r_b_rvalid;
   logic              r_collision;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_CLEAR;
         r_clr_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      case (r_state)
         S_CLEAR: begin
            w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
            if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
               w_state_nxt   = S_READY;
               w_clr_cnt_nxt = '0;
            end
         end
         S_READY: begin
            if (bus.clr_req) begin
               w_state_nxt   = S_CLEAR;
               w_clr_cnt_nxt = '0;
            end
         end
         default: begin
            w_state_nxt   = S_CLEAR;
            w_clr_cnt_nxt = '0;
         end
      endcase
   end

   assign w_ready   = (r_state == S_READY);
   assign w_clr_wr  = (r_state == S_CLEAR);
   assign bus.ready = w_ready;

   assign w_a_rd     = w_ready & bus.a_en & ~bus.a_we;
   assign w_b_rd     = w_ready & bus.b_en & ~bus.b_we;
   assign w_a_wr     = w_ready & bus.a_en &  bus.a_we;
   assign w_b_wr     = w_ready & bus.b_en &  bus.b_we;
   assign w_a_eff_wr = w_a_wr & (|bus.a_be);
   assign w_b_eff_wr = w_b_wr & (|bus.b_be);

   // A byte written by both ports at one address takes port A data: A's
   // assignment comes last, so it wins the non-blocking update.
   always_ff @(posedge clk) begin
      if (w_clr_wr) begin
         r_mem[r_clr_cnt] <= '0;
      end else begin
         for (int i = 0; i < BYTES; i++) begin
            if (w_b_wr && bus.b_be[i])
               r_mem[bus.b_addr][8*i +: 8] <= bus.b_wdata[8*i +: 8];
            if (w_a_wr && bus.a_be[i])
               r_mem[bus.a_addr][8*i +: 8] <= bus.a_wdata[8*i +: 8];
         end
      end
   end

   // Reads sample the array before this edge's writes land (read-before-write).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_rdata  <= '0;
         r_a_rvalid <= 1'b0;
         r_b_rdata  <= '0;
         r_b_rvalid <= 1'b0;
      end else begin
         r_a_rvalid <= w_a_rd;
         r_b_rvalid <= w_b_rd;
         if (w_a_rd)
            r_a_rdata <= r_mem[bus.a_addr];
         if (w_b_rd)
            r_b_rdata <= r_mem[bus.b_addr];
      end
   end

   assign w_same_addr = bus.a_en & bus.b_en & (bus.a_addr == bus.b_addr);
   assign w_collision = w_ready & w_same_addr & (w_a_eff_wr | w_b_eff_wr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_collision <= 1'b0;
      else
         r_collision <= w_collision;
   end

   assign bus.collision = r_collision;

`ifdef DPRAM_OUT_REG_EN
   logic [DATA_W-1:0] r_a_rdata_q;
   logic              r_a_rvalid_q;
   logic [DATA_W-1:0] r_b_rdata_q;
   logic              r_b_rvalid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_rdata_q  <= '0;
         r_a_rvalid_q <= 1'b0;
         r_b_rdata_q  <= '0;
         r_b_rvalid_q <= 1'b0;
      end else begin
         r_a_rdata_q  <= r_a_rdata;
         r_a_rvalid_q <= r_a_rvalid;
         r_b_rdata_q  <= r_b_rdata;
         r_b_rvalid_q <= r_b_rvalid;
      end
   end

   assign bus.a_rdata  = r_a_rdata_q;
   assign bus.a_rvalid = r_a_rvalid_q;
   assign bus.b_rdata  = r_b_rdata_q;
   assign bus.b_rvalid = r_b_rvalid_q;
`else
   assign bus.a_rdata  = r_a_rdata;
   assign bus.a_rvalid = r_a_rvalid;
   assign bus.b_rdata  = r_b_rdata;
   assign bus.b_rvalid = r_b_rvalid;
`endif

endmodule
